// File: rtl/key_note_scheduler_if.sv
// key_note_scheduler_if: keypad, beat and player-control signals between the scheduler and its driver
interface key_note_scheduler_if #(parameter int DEPTH = 4);
    logic                     key_strobe;
    logic [3:0]               key_code;
    logic                     beat;
    logic                     run;
    logic                     flush;
    logic [3:0]               key_val;
    logic                     note_enable;
    logic                     note_start;
    logic                     busy;
    logic [$clog2(DEPTH):0]   queue_count;
    logic                     overflow;
    modport master (
        output key_strobe, key_code, beat, run, flush,
        input  key_val, note_enable, note_start, busy, queue_count, overflow
    );
    modport slave (
        input  key_strobe, key_code, beat, run, flush,
        output key_val, note_enable, note_start, busy, queue_count, overflow
    );
endinterface

// File: rtl/key_note_scheduler.sv
// key_note_scheduler: queues key strobes and plays them one at a time for NOTE_BEATS beats plus a GAP_BEATS silence
module key_note_scheduler #(
    parameter int DEPTH      = 4,
    parameter int NOTE_BEATS = 4,
    parameter int GAP_BEATS  = 1
) (
    input logic                  clk,
    input logic                  reset,
    key_note_scheduler_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    cnt;
    logic          full, pop, push, tick;
    assign full  = count == (AW+1)'(DEPTH);
    assign pop   = state == IDLE && count != '0 && bus.run;
    // a pop in the same cycle frees the slot, so a strobe into a full queue still fits
    assign push  = bus.key_strobe && (!full || pop);
    assign tick  = bus.beat && bus.run;
    assign bus.busy        = state != IDLE;
    assign bus.queue_count = count;
    always_ff @(posedge clk)
        if (reset && !bus.flush && push) mem[wr_ptr] <= bus.key_code;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            cnt             <= '0;
            bus.key_val     <= '0;
            bus.note_enable <= 1'b0;
            bus.note_start  <= 1'b0;
            bus.overflow    <= 1'b0;
        end else if (bus.flush) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            bus.note_enable <= 1'b0;
            bus.note_start  <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.note_start <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (bus.key_strobe && !push) bus.overflow <= 1'b1;
            case (state)
                IDLE: if (pop) begin
                    bus.key_val <= mem[rd_ptr];
                    state       <= LOAD;
                end
                LOAD: begin
                    state           <= PLAY;
                    cnt             <= 8'(NOTE_BEATS);
                    bus.note_enable <= bus.key_val != 4'd0;
                    bus.note_start  <= 1'b1;
                end
                PLAY: if (tick) begin
                    if (cnt == 8'd1) begin
                        bus.note_enable <= 1'b0;
                        state           <= (GAP_BEATS > 0) ? GAP : IDLE;
                        cnt             <= 8'(GAP_BEATS);
                    end else cnt <= cnt - 8'd1;
                end
                GAP: if (tick) begin
                    if (cnt == 8'd1) state <= IDLE;
                    else cnt <= cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/key_note_scheduler.md
Name: key_note_scheduler

Overview:
- Sequencer in front of key_board.
- Queues keypad strobes in a small FIFO and presents one key code at a time on key_val.
- Gates the note player's enable for a fixed number of beats per note, followed by an optional silent gap.
- Rapid key presses become an ordered melody instead of overwriting each other.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
NOTE_BEATS, 4, beats each note is held enabled (≥1, fits 8 bits)
GAP_BEATS, 1, silent beats after each note (0 = no gap, fits 8 bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
key_strobe  in  1  one-cycle pulse: key_code valid, push request
key_code  in  4  keypad code; 0 = rest
beat  in  1  one-cycle beat tick
run  in  1  1 = advance; 0 = pause (counters frozen, outputs held)
flush  in  1  one-cycle pulse: discard queue, stop current note
key_val  out  4  code to key_board/note_rom
note_enable  out  1  enable to key_board
note_start  out  1  one-cycle pulse when note_enable rises (or a rest begins)
busy  out  1  state != IDLE
queue_count  out  clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a strobe was dropped because the FIFO was full

Behaviour:
- Reset (reset==0 at a clk edge):
  - key_val=0, note_enable=0, note_start=0, busy=0, queue_count=0, overflow=0.
  - Pointers cleared; state=IDLE.
  - Mid-note reset aborts immediately; no residual enable.
- FIFO:
  - Push on key_strobe when not full.
  - Pop only on IDLE→LOAD.
  - Push and pop in the same cycle: both take effect, count unchanged.
  - Push while full with no pop in that cycle: dropped, overflow<=1.
  - Push while full with a pop in that cycle: accepted.
  - Pointers wrap modulo DEPTH.
- States: IDLE, LOAD, PLAY, GAP.
  - IDLE:
    - note_enable=0.
    - If queue non-empty and run=1: pop head into key_val, go LOAD.
    - A strobe into an empty FIFO is not visible to IDLE until the following cycle, so the minimum strobe→LOAD latency is 2 cycles.
  - LOAD:
    - One cycle, covering the registered note_rom read latency.
    - Next cycle: PLAY, beat counter=NOTE_BEATS.
    - note_enable<=1 if key_val!=0, else 0 (rest).
    - note_start pulses for exactly one cycle.
  - PLAY:
    - On beat && run: if counter==1, exit; else counter-1.
    - Exit: note_enable<=0; go to GAP with counter=GAP_BEATS if GAP_BEATS>0, else IDLE.
  - GAP:
    - note_enable=0; key_val held.
    - Same countdown on beat && run; go to IDLE when counter==1 on a beat.
  - LOAD advances regardless of run.
- Pause (run=0): beats ignored; state, counter and key_val frozen; note_enable keeps its value, so the player mutes itself via beat gating.
- A beat arriving in the LOAD cycle is not counted.
- Note length: exactly NOTE_BEATS counted beats after entering PLAY; the first counted beat may be partial.
- flush:
  - Next cycle: FIFO empty, state=IDLE, note_enable=0, overflow=0; key_val retains its last value.
  - flush with key_strobe in the same cycle: flush wins, strobe discarded.
  - flush overrides all other events except reset.
- Counter width: 8 bits, no underflow (exit taken at 1).

Test Plan:
1. Reset with reset=0, then release; strobe code 5 at cycle 0 with run=1 -> LOAD at cycle 2, key_val=5; note_enable=1 and note_start=1 at cycle 3; note_enable falls on the 4th beat; GAP lasts 1 beat; busy=0 afterwards.
2. Five strobes (codes 1..5) back-to-back in IDLE with DEPTH=4 -> codes 1..4 queued, overflow=1; notes play in order 1,2,3,4; code 5 is never output.
3. Strobe code 0 -> rest: note_start pulses, note_enable stays 0 for 4 beats, then the next queued note plays.
4. run=0 during the 2nd beat of a note, 3 beats issued, then run=1 -> counter frozen; note ends on the 2 remaining beats after resume; key_val unchanged throughout.
5. flush mid-PLAY with 2 entries queued and a simultaneous key_strobe -> next cycle note_enable=0, queue_count=0, busy=0, overflow cleared; no note follows.
6. FIFO full, pop on IDLE→LOAD coinciding with a strobe -> strobe accepted, queue_count stays 4, overflow remains 0; pointer wrap verified by playing 8 sequential notes in order.
